// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared widths, grant source encoding and request record for the write-back arbiter.
package wb_arb_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  typedef enum logic [1:0] {SRC_NONE, SRC_MEM, SRC_EX} src_t;
  typedef struct packed {
    logic [ADDR_W_DEF-1:0] rd;
    logic [DATA_W_DEF-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/wb_hold_slot.sv
// wb_hold_slot: 1-deep request holding register; can drain and refill on the same edge.
module wb_hold_slot
  import wb_arb_pkg::*;
#(
  parameter int W = ADDR_W_DEF + DATA_W_DEF
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_flush,
  input  logic         i_valid,
  input  logic [W-1:0] i_req,
  input  logic         i_drain,
  output logic         o_ready,
  output logic         o_full,
  output logic [W-1:0] o_req
);
  logic         r_full;
  logic [W-1:0] r_req;

  assign o_ready = !i_flush && (!r_full || i_drain);
  assign o_full  = r_full;
  assign o_req   = r_req;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_full <= 1'b0;
      r_req  <= '0;
    end else if (i_flush) begin
      r_full <= 1'b0;
    end else if (i_valid && o_ready) begin
      r_full <= 1'b1;
      r_req  <= i_req;
    end else if (i_drain) begin
      r_full <= 1'b0;
    end
  end
endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between MEM and EX (MEM first,
// EX forced through after STARVE_LIMIT consecutive losses) and publishes a pending-write bitmap.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int NREGS        = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_flush,
  input  logic              i_mem_valid,
  output logic              o_mem_ready,
  input  logic [ADDR_W-1:0] i_mem_rd,
  input  logic [DATA_W-1:0] i_mem_data,
  input  logic              i_ex_valid,
  output logic              o_ex_ready,
  input  logic [ADDR_W-1:0] i_ex_rd,
  input  logic [DATA_W-1:0] i_ex_data,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [DATA_W-1:0] o_wr_data,
  output logic [NREGS-1:0]  o_busy
);
  localparam int W  = ADDR_W + DATA_W;
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic              w_mem_full, w_ex_full, w_starved;
  logic [W-1:0]      w_mem_q, w_ex_q;
  logic [ADDR_W-1:0] w_mem_rd, w_ex_rd, w_sel_rd, r_last_addr;
  logic [DATA_W-1:0] w_mem_data, w_ex_data, w_sel_data, r_last_data;
  logic [NREGS-1:0]  w_mem_oh, w_ex_oh, w_oh;
  logic [CW-1:0]     r_starve;
  src_t              w_grant;

  wb_hold_slot #(.W(W)) u_mem_slot (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush),
    .i_valid(i_mem_valid), .i_req({i_mem_rd, i_mem_data}),
    .i_drain(w_grant == SRC_MEM), .o_ready(o_mem_ready),
    .o_full(w_mem_full), .o_req(w_mem_q)
  );

  wb_hold_slot #(.W(W)) u_ex_slot (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush),
    .i_valid(i_ex_valid), .i_req({i_ex_rd, i_ex_data}),
    .i_drain(w_grant == SRC_EX), .o_ready(o_ex_ready),
    .o_full(w_ex_full), .o_req(w_ex_q)
  );

  assign {w_mem_rd, w_mem_data} = w_mem_q;
  assign {w_ex_rd, w_ex_data}   = w_ex_q;

  // Same-rd pairs never let EX jump ahead, so the older MEM value cannot overwrite it.
  assign w_starved = (r_starve == CW'(STARVE_LIMIT)) && (w_mem_rd != w_ex_rd);
  assign w_grant   = (w_mem_full && w_ex_full) ? (w_starved ? SRC_EX : SRC_MEM) :
                     w_mem_full ? SRC_MEM : w_ex_full ? SRC_EX : SRC_NONE;

  assign w_sel_rd   = (w_grant == SRC_EX) ? w_ex_rd : w_mem_rd;
  assign w_sel_data = (w_grant == SRC_EX) ? w_ex_data : w_mem_data;
  assign o_wr_en    = (w_grant != SRC_NONE) && !i_flush && (w_sel_rd != '0);
  assign o_wr_addr  = (w_grant == SRC_NONE) ? r_last_addr : w_sel_rd;
  assign o_wr_data  = (w_grant == SRC_NONE) ? r_last_data : w_sel_data;

  // Shifting past NREGS drops the bit, so out-of-range indices never flag busy.
  assign w_mem_oh = {{(NREGS-1){1'b0}}, w_mem_full} << w_mem_rd;
  assign w_ex_oh  = {{(NREGS-1){1'b0}}, w_ex_full} << w_ex_rd;
  assign w_oh     = w_mem_oh | w_ex_oh;
  assign o_busy   = {w_oh[NREGS-1:1], 1'b0};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_starve    <= '0;
      r_last_addr <= '0;
      r_last_data <= '0;
    end else begin
      r_starve <= (i_flush || !w_ex_full || w_grant == SRC_EX) ? '0 :
                  (r_starve == CW'(STARVE_LIMIT)) ? r_starve : r_starve + 1'b1;
      if (o_wr_en) begin
        r_last_addr <= w_sel_rd;
        r_last_data <= w_sel_data;
      end
    end
  end
endmodule
